// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: frame framing, command
// shape and the loader state encoding.
package program_loader_pkg;

  localparam int MAX_NUM_COMMANDS = 16;
  localparam int ADDR_W           = $clog2(MAX_NUM_COMMANDS);
  localparam int CMD_BYTES        = 3;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Instruction byte in the MSBs, then address, then data.
  typedef logic [8*CMD_BYTES-1:0] CommandType;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SYNC,
    ST_COUNT,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_CHECK,
    ST_ERROR
  } LoaderStateType;

  // States in which the byte stream is being consumed inside a frame.
  function automatic logic frame_byte_state(input LoaderStateType s);
    return (s == ST_COUNT) || (s == ST_PAYLOAD) || (s == ST_CKSUM);
  endfunction

endpackage

// File: rtl/program_loader_timer.sv
// Inter-byte gap watchdog: counts enabled cycles since the last clear and
// flags the cycle that completes TIMEOUT_CYCLES without a clear.
module program_loader_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk_in,
  input  logic nrst_in,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is evaluated in the cycle itself so the state machine leaves on
  // exactly the TIMEOUT_CYCLES-th idle edge.
  assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/program_loader.sv
// Receives a framed program over the byte stream, writes it into program
// memory while holding the core in reset, and releases the core on a good checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQUENCY / 10
) (
  input  logic              clk_in,
  input  logic              nrst_in,
  input  logic              load_req_in,
  input  logic [7:0]        rx_data_in,
  input  logic              rx_valid_in,
  output logic              rx_ready_out,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output CommandType        wr_data_out,
  output logic              core_nrst_out,
  output logic              loading_out,
  output logic              error_out
);

  localparam int ASM_W = 8 * (CMD_BYTES - 1);
  localparam logic [1:0] LAST_BYTE = 2'(CMD_BYTES - 1);

  LoaderStateType    state_q, state_d;
  logic [ADDR_W-1:0] n_last_q, n_last_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        cksum_q, cksum_d;
  logic              core_nrst_q;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  CommandType        wr_data_q, wr_data_d;

  logic accept;
  logic timer_expired;

  assign rx_ready_out = (state_q == ST_SYNC) || frame_byte_state(state_q);
  assign accept       = rx_valid_in && rx_ready_out;

  program_loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in   (clk_in),
    .nrst_in  (nrst_in),
    .clear_i  (accept),
    .enable_i (frame_byte_state(state_q)),
    .expired_o(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    n_last_d   = n_last_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    sum_d      = sum_q;
    cksum_d    = cksum_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      ST_RUN: begin
        if (load_req_in) state_d = ST_SYNC;
      end

      ST_SYNC: begin
        if (accept && rx_data_in == SYNC_BYTE) state_d = ST_COUNT;
      end

      ST_COUNT: begin
        if (accept) begin
          if (rx_data_in == 8'd0 || int'(rx_data_in) > MAX_NUM_COMMANDS) begin
            state_d = ST_ERROR;
          end else begin
            // Storing N-1 keeps the bound inside the index width.
            n_last_d   = ADDR_W'(rx_data_in - 8'd1);
            index_d    = '0;
            byte_cnt_d = '0;
            sum_d      = rx_data_in;
            state_d    = ST_PAYLOAD;
          end
        end else if (timer_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_PAYLOAD: begin
        if (accept) begin
          sum_d = sum_q + rx_data_in;
          if (byte_cnt_q == LAST_BYTE) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = index_q;
            wr_data_d  = {asm_q, rx_data_in};
            byte_cnt_d = '0;
            if (index_q == n_last_q) begin
              state_d = ST_CKSUM;
            end else begin
              index_d = index_q + ADDR_W'(1);
            end
          end else begin
            asm_d      = {asm_q[ASM_W-9:0], rx_data_in};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (timer_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_CKSUM: begin
        if (accept) begin
          cksum_d = rx_data_in;
          state_d = ST_CHECK;
        end else if (timer_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_CHECK: begin
        state_d = (cksum_q == sum_q) ? ST_RUN : ST_ERROR;
      end

      ST_ERROR: begin
        if (load_req_in) state_d = ST_SYNC;
      end

      default: state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q     <= ST_RUN;
      n_last_q    <= '0;
      index_q     <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      sum_q       <= '0;
      cksum_q     <= '0;
      core_nrst_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      n_last_q    <= n_last_d;
      index_q     <= index_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      sum_q       <= sum_d;
      cksum_q     <= cksum_d;
      // Registered so the core leaves reset on the first edge after nrst_in rises.
      core_nrst_q <= (state_d == ST_RUN);
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_en_out     = wr_en_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign core_nrst_out = core_nrst_q;
  assign loading_out   = (state_q == ST_SYNC) || frame_byte_state(state_q)
                         || (state_q == ST_CHECK);
  assign error_out     = (state_q == ST_ERROR);

endmodule
